// File: rtl/pipe_trace_pkg.sv
// rtl/pipe_trace_pkg.sv - shared types and constants for the pipeline trace monitor
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    localparam logic [1:0] TRIG_PC    = 2'd0;
    localparam logic [1:0] TRIG_FLUSH = 2'd1;
    localparam logic [1:0] TRIG_NOW   = 2'd2;

    localparam int TRACE_XLEN = 32;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit event counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_trace_monitor.sv
// rtl/pipe_trace_monitor.sv - writeback trace buffer with trigger and saturating event counters
module pipe_trace_monitor
    import pipe_trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [XLEN-1:0]          wb_pc,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [1:0]               forward_a,
    input  logic [1:0]               forward_b,
    input  logic                     arm,
    input  logic [1:0]               trig_mode,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [XLEN-1:0]          rd_pc,
    output logic [4:0]               rd_rd,
    output logic [XLEN-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   entry_cnt,
    output logic [1:0]               state,
    output logic [CNT_W-1:0]         cyc_cnt,
    output logic [CNT_W-1:0]         ret_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt,
    output logic [CNT_W-1:0]         fwd_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [CW-1:0] POST_TRIG_C = CW'(POST_TRIG);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    trace_state_e   state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  post_q, post_d;
    logic           rd_valid_q, rd_valid_d;
    entry_t         rd_entry_q, rd_entry_d;
    entry_t         mem_q [DEPTH];

    logic   capture;
    logic   cap_wr;
    logic   pop;
    logic   trig_hit;
    entry_t wr_entry;

    assign capture  = !arm && ((state_q == ARMED) || (state_q == POST));
    assign cap_wr   = capture && wb_valid;
    assign pop      = !arm && (state_q == DONE) && rd_req && (cnt_q != '0);
    assign wr_entry = {wb_pc, wb_rd, wb_data};

    always_comb begin
        case (trig_mode)
            TRIG_PC:    trig_hit = wb_valid && (wb_pc == trig_pc);
            TRIG_FLUSH: trig_hit = flush;
            default:    trig_hit = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        post_d     = post_q;
        rd_valid_d = 1'b0;
        rd_entry_d = rd_entry_q;
        if (arm) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            post_d   = '0;
            if ((trig_mode == TRIG_PC) || (trig_mode == TRIG_FLUSH)) begin
                state_d = ARMED;
            end else begin
                state_d = (POST_TRIG == 0) ? DONE : POST;
            end
        end else begin
            // A full buffer drops its oldest entry so the newest always lands.
            if (cap_wr) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (cnt_q == DEPTH_C) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            if (pop) begin
                rd_valid_d = 1'b1;
                rd_entry_d = mem_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                cnt_d      = cnt_q - CNT_ONE;
            end
            case (state_q)
                ARMED: begin
                    if (trig_hit) begin
                        state_d = (POST_TRIG == 0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (cap_wr) begin
                        post_d = post_q + CNT_ONE;
                        if (post_d == POST_TRIG_C) begin
                            state_d = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            post_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            post_q     <= post_d;
            rd_valid_q <= rd_valid_d;
            rd_entry_q <= rd_entry_d;
        end
    end

    // Storage needs no reset; entry_cnt alone defines what is live.
    always_ff @(posedge clk) begin
        if (cap_wr) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    sat_counter #(.W(CNT_W)) u_cyc (
        .clk(clk), .rst(rst), .clr(arm), .inc(capture), .q(cyc_cnt)
    );
    sat_counter #(.W(CNT_W)) u_ret (
        .clk(clk), .rst(rst), .clr(arm), .inc(capture && wb_valid), .q(ret_cnt)
    );
    sat_counter #(.W(CNT_W)) u_stall (
        .clk(clk), .rst(rst), .clr(arm), .inc(capture && stall), .q(stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush (
        .clk(clk), .rst(rst), .clr(arm), .inc(capture && flush), .q(flush_cnt)
    );
    sat_counter #(.W(CNT_W)) u_fwd (
        .clk(clk), .rst(rst), .clr(arm),
        .inc(capture && ((forward_a != 2'd0) || (forward_b != 2'd0))), .q(fwd_cnt)
    );

    assign state     = state_q;
    assign entry_cnt = cnt_q;
    assign rd_valid  = rd_valid_q;
    assign rd_pc     = rd_entry_q.pc;
    assign rd_rd     = rd_entry_q.rd;
    assign rd_data   = rd_entry_q.data;

endmodule

// File: doc/pipe_trace_monitor.md
Name: pipe_trace_monitor

Overview:
- Synthesizable on-chip debug block for the 5-stage pipeline core, instantiated beside `top`.
- Passively taps writeback, hazard and forwarding signals.
- Captures retired writebacks into a parametrised circular trace buffer around a selectable trigger.
- Keeps saturating event counters (cycles, retires, stalls, flushes, forwards) for post-run readout through a simple request/valid port.

Parameters:
- XLEN, 32, PC and data width.
- DEPTH, 16, trace entries; power of 2, at least 2.
- POST_TRIG, 8, entries captured after the trigger cycle; 0 to DEPTH.
- CNT_W, 32, event counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wb_valid  in  1  writeback retires this cycle.
- wb_pc  in  XLEN  PC of retiring instruction.
- wb_rd  in  5  destination register.
- wb_data  in  XLEN  writeback data.
- stall  in  1  hazard unit stall.
- flush  in  1  hazard unit flush.
- forward_a  in  2  forwarding select, operand A.
- forward_b  in  2  forwarding select, operand B.
- arm  in  1  pulse: clear buffer and counters, start capture.
- trig_mode  in  2  0 = PC match, 1 = first flush, 2 = immediate, 3 = reserved (treated as 2).
- trig_pc  in  XLEN  PC compared in mode 0.
- rd_req  in  1  pop oldest entry.
- rd_valid  out  1  rd_pc/rd_rd/rd_data valid.
- rd_pc  out  XLEN  popped PC.
- rd_rd  out  5  popped rd.
- rd_data  out  XLEN  popped data.
- entry_cnt  out  $clog2(DEPTH)+1  entries held.
- state  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.
- cyc_cnt, ret_cnt, stall_cnt, flush_cnt, fwd_cnt  out  CNT_W each  event counters.

Behaviour:
- Reset values: state = IDLE; pointers, entry_cnt and all counters = 0; rd_valid = 0; rd_pc/rd_rd/rd_data = 0.
- arm, any state, takes priority over everything else:
  - Next cycle: buffer empty, counters 0, post counter 0.
  - State becomes ARMED, or POST when trig_mode is 2 or 3.
- Capture, in ARMED and POST only:
  - When wb_valid, write {wb_pc, wb_rd, wb_data} at the write pointer and increment it modulo DEPTH.
  - Buffer full: overwrite the oldest entry and advance the read pointer; entry_cnt stays DEPTH.
  - wb_rd = 0 retires are captured like any other retire.
- Trigger, evaluated in ARMED only:
  - Mode 0: wb_valid && wb_pc == trig_pc.
  - Mode 1: flush.
  - On trigger, that cycle's entry (if any) is written and state becomes POST next cycle.
- POST:
  - Each captured entry after the trigger cycle increments the post counter.
  - The cycle the post counter reaches POST_TRIG, state becomes DONE next cycle.
  - POST_TRIG = 0: trigger goes straight to DONE, skipping POST.
  - Immediate mode with POST_TRIG = 0: arm leads to DONE next cycle with an empty buffer.
- Counters:
  - Increment only in ARMED and POST.
  - Each saturates at 2^CNT_W - 1.
  - cyc_cnt: every cycle.
  - ret_cnt: on wb_valid.
  - stall_cnt: on stall.
  - flush_cnt: on flush.
  - fwd_cnt: once per cycle when forward_a != 0 or forward_b != 0.
  - All hold their values in DONE and IDLE.
- Readout, in DONE only:
  - rd_req with entry_cnt > 0: next cycle rd_valid = 1 with the oldest entry, the read pointer advances and entry_cnt decrements.
  - rd_req with an empty buffer, or in any other state: next cycle rd_valid = 0 and data outputs hold.
  - rd_valid is a one-cycle pulse per pop.
  - Back-to-back rd_req gives one entry per cycle.
- Simultaneous arm and rd_req: arm wins and rd_valid = 0.
- Reset mid-capture or mid-readout: return to the reset state at the next edge; the buffer contents become don't-care and the buffer is logically empty.

Decomposition:
- Package pipe_trace_pkg holds:
  - trace_state_e (IDLE/ARMED/POST/DONE).
  - Trigger mode constants TRIG_PC, TRIG_FLUSH, TRIG_NOW.
  - trace_entry_t packed struct {pc, rd, data}, parametrised via XLEN localparam or per-instance typedef.
- One sub-module, sat_counter (parameter W; inputs clr and inc; output q), instantiated five times.
- Storage is an inferred register array inside pipe_trace_monitor.

Test Plan:
1. Reset, then 5 idle cycles → state = 0, entry_cnt = 0, rd_valid = 0, all counters 0; rd_req ignored.
2. DEPTH = 16, POST_TRIG = 4, mode 0, trig_pc = 0x40. Retire PCs 0x00, 0x04, ... to 0x40, then 4 more retires → state = 3, entry_cnt = 16. Popping 16 entries returns PCs 0x14 through 0x50 in order; a 17th rd_req gives rd_valid = 0.
3. Mode 1: flush asserted on the 10th cycle after arm, with 3 stalls and 2 cycles of forward_a = 2 before it → flush_cnt = 1, stall_cnt = 3, fwd_cnt = 2, cyc_cnt = 10 at the trigger cycle; state moves to POST.
4. Mode 2, POST_TRIG = 0: arm → DONE next cycle, entry_cnt = 0; counters stay 0 over 20 further cycles.
5. CNT_W = 4, mode 0 with a trig_pc that never matches: 20 cycles of wb_valid → ret_cnt = 15, cyc_cnt = 15 (saturated).
6. In DONE with 16 entries: pop 3, then assert arm and rd_req together → rd_valid = 0 next cycle, state = 1, entry_cnt = 0, counters 0. After that, assert rst during POST → state = 0 next cycle.
